sync_fifo_bram: RTL and testbench

- Parametrised synchronous FIFO whose storage is a synchronous-read array, so synthesis maps it to block RAM instead of LUTs.
- Supports two read modes, selected by parameter: standard (1-cycle read latency) and first-word-fall-through (FWFT, via a prefetch output register).
- Provides occupancy count, almost-full/almost-empty thresholds and single-cycle overflow/underflow error pulses.
- Sits between producer and consumer logic in the same clock domain. It is the next-generation FIFO core for the design.

---
 rtl/sync_fifo_bram.sv | 94 +++++++++
 tb/tb_sync_fifo_bram.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_bram.sv
// Synchronous FIFO with block-RAM storage (synchronous read), in standard
// (1-cycle read latency) or first-word-fall-through mode.
module sync_fifo_bram #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 2;
  localparam int CAP   = (FWFT != 0) ? DEPTH + 1 : DEPTH;
  localparam logic [CW-1:0] CAP_C = CW'(CAP);
  localparam logic [CW-1:0] AF_C  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C  = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  out_valid;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_rd;
  logic [CW-1:0]         mem_count;

  // In FWFT mode count includes the output register, so the memory holds
  // count - out_valid words; the memory is read whenever the head slot frees up.
  always_comb begin
    full         = (count == CAP_C);
    empty        = (FWFT != 0) ? !out_valid : (count == '0);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
    rd_acc       = rd_en && !empty;
    wr_acc       = wr_en && (!full || rd_acc);
    mem_count    = count - CW'(out_valid);
    if (FWFT != 0)
      mem_rd = (mem_count != '0) && (!out_valid || rd_acc);
    else
      mem_rd = rd_acc;
  end

  // Storage kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset)
      mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      r_data    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (mem_rd) begin
        r_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (wr_acc && !rd_acc)
        count <= count + CW'(1);
      else if (rd_acc && !wr_acc)
        count <= count - CW'(1);
      if (FWFT != 0) begin
        if (mem_rd)
          out_valid <= 1'b1;
        else if (rd_acc)
          out_valid <= 1'b0;
      end
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo_bram.sv
// Directed bench for sync_fifo_bram: one standard-mode and one FWFT instance,
// each scenario task checks its own expected values inline.
module tb_sync_fifo_bram;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       s_wr_en = 1'b0, s_rd_en = 1'b0;
  logic [7:0] s_w_data = '0, s_r_data;
  logic       s_full, s_empty, s_af, s_ae, s_ov, s_un;
  logic [4:0] s_count;

  logic       f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [7:0] f_w_data = '0, f_r_data;
  logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;
  logic [4:0] f_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_fifo_bram #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .FWFT(0)) dut_std (
    .clk(clk), .reset(reset), .wr_en(s_wr_en), .w_data(s_w_data), .rd_en(s_rd_en),
    .r_data(s_r_data), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ov), .underflow(s_un)
  );

  sync_fifo_bram #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset), .wr_en(f_wr_en), .w_data(f_w_data), .rd_en(f_rd_en),
    .r_data(f_r_data), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ov), .underflow(f_un)
  );

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_wr_en = 0; s_rd_en = 0; f_wr_en = 0; f_rd_en = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({s_full, s_empty, s_af, s_ae, s_ov, s_un} !== 6'b010100) begin
      errors++;
      $display("[TB] FAIL reset_std_flags: got %b expected 010100",
               {s_full, s_empty, s_af, s_ae, s_ov, s_un});
    end
    checks++;
    if (s_count !== 5'd0 || s_r_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_std_count_data: got count=%0d data=%h expected 0/00", s_count, s_r_data);
    end
    checks++;
    if ({f_full, f_empty, f_af, f_ae, f_ov, f_un} !== 6'b010100 || f_count !== 5'd0 || f_r_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_fwft: got flags=%b count=%0d data=%h expected 010100/0/00",
               {f_full, f_empty, f_af, f_ae, f_ov, f_un}, f_count, f_r_data);
    end
  endtask

  task automatic test_std_fill_drain();
    logic [7:0] exp;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      s_wr_en = 1; s_w_data = 8'(8'h11 * i);
      tick();
      checks++;
      if (s_count !== 5'(i) || s_full !== (i == 8) || s_af !== (i >= 7) || s_empty !== 1'b0) begin
        errors++;
        $display("[TB] FAIL std_fill_%0d: got count=%0d full=%b af=%b empty=%b expected %0d/%b/%b/0",
                 i, s_count, s_full, s_af, s_empty, i, (i == 8), (i >= 7));
      end
    end
    s_w_data = 8'h99;
    tick();
    checks++;
    if (s_ov !== 1'b1 || s_count !== 5'd8) begin
      errors++;
      $display("[TB] FAIL std_overflow: got ov=%b count=%0d expected 1/8", s_ov, s_count);
    end
    s_wr_en = 0;
    tick();
    checks++;
    if (s_ov !== 1'b0) begin
      errors++;
      $display("[TB] FAIL std_overflow_pulse: got ov=%b expected 0", s_ov);
    end
    for (int i = 1; i <= 8; i++) begin
      s_rd_en = 1;
      tick();
      exp = 8'(8'h11 * i);
      checks++;
      if (s_r_data !== exp || s_count !== 5'(8 - i) || s_empty !== (i == 8)) begin
        errors++;
        $display("[TB] FAIL std_read_%0d: got data=%h count=%0d empty=%b expected %h/%0d/%b",
                 i, s_r_data, s_count, s_empty, exp, 8 - i, (i == 8));
      end
    end
    s_rd_en = 0;
    tick();
    checks++;
    if (s_r_data !== 8'h88 || s_un !== 1'b0) begin
      errors++;
      $display("[TB] FAIL std_hold: got data=%h un=%b expected 88/0", s_r_data, s_un);
    end
  endtask

  task automatic test_fwft_fall_through();
    do_reset();
    f_wr_en = 1; f_w_data = 8'hA5;
    tick();
    f_wr_en = 0;
    checks++;
    if (f_empty !== 1'b1 || f_count !== 5'd1) begin
      errors++;
      $display("[TB] FAIL fwft_cycle1: got empty=%b count=%0d expected 1/1", f_empty, f_count);
    end
    tick();
    checks++;
    if (f_empty !== 1'b0 || f_r_data !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL fwft_cycle2: got empty=%b data=%h expected 0/a5", f_empty, f_r_data);
    end
    tick();
    checks++;
    if (f_empty !== 1'b0 || f_r_data !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL fwft_stable: got empty=%b data=%h expected 0/a5", f_empty, f_r_data);
    end
    f_rd_en = 1;
    tick();
    f_rd_en = 0;
    checks++;
    if (f_empty !== 1'b1 || f_count !== 5'd0 || f_un !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fwft_pop: got empty=%b count=%0d un=%b expected 1/0/0", f_empty, f_count, f_un);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      f_wr_en = 1; f_w_data = 8'(8'h40 + i);
      tick();
    end
    checks++;
    if (f_full !== 1'b1 || f_count !== 5'd9 || f_r_data !== 8'h40 || f_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fwft_full: got full=%b count=%0d data=%h empty=%b expected 1/9/40/0",
               f_full, f_count, f_r_data, f_empty);
    end
    f_rd_en = 1;
    for (int k = 0; k < 20; k++) begin
      f_w_data = 8'(8'h49 + k);
      tick();
      exp = 8'(8'h41 + k);
      checks++;
      if (f_ov !== 1'b0 || f_un !== 1'b0 || f_count !== 5'd9 || f_r_data !== exp) begin
        errors++;
        $display("[TB] FAIL fwft_stream_%0d: got ov=%b un=%b count=%0d data=%h expected 0/0/9/%h",
                 k, f_ov, f_un, f_count, f_r_data, exp);
      end
    end
    f_wr_en = 0;
    for (int j = 0; j < 9; j++) begin
      tick();
      exp = 8'(8'h55 + j);
      checks++;
      if (f_count !== 5'(8 - j) || f_empty !== (j == 8) || (j < 8 && f_r_data !== exp)) begin
        errors++;
        $display("[TB] FAIL fwft_drain_%0d: got count=%0d empty=%b data=%h expected %0d/%b/%h",
                 j, f_count, f_empty, f_r_data, 8 - j, (j == 8), exp);
      end
    end
    f_rd_en = 0;
  endtask

  task automatic test_underflow();
    do_reset();
    s_rd_en = 1;
    tick();
    checks++;
    if (s_un !== 1'b1 || s_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL std_underflow: got un=%b count=%0d expected 1/0", s_un, s_count);
    end
    s_wr_en = 1; s_w_data = 8'h3C;
    tick();
    s_wr_en = 0;
    checks++;
    if (s_un !== 1'b1 || s_count !== 5'd1 || s_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL std_rw_on_empty: got un=%b count=%0d empty=%b expected 1/1/0", s_un, s_count, s_empty);
    end
    tick();
    s_rd_en = 0;
    checks++;
    if (s_r_data !== 8'h3C || s_un !== 1'b0 || s_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL std_read_3c: got data=%h un=%b count=%0d expected 3c/0/0", s_r_data, s_un, s_count);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] exp_data;
    logic       wr, rd, rd_ok, wr_ok;
    do_reset();
    exp_data = 8'h00;
    for (int c = 0; c < 50; c++) begin
      wr = ($urandom_range(99, 0) < 60);
      rd = ($urandom_range(99, 0) < 50);
      rd_ok = rd && (q.size() != 0);
      wr_ok = wr && (q.size() < 8 || rd_ok);
      s_wr_en = wr; s_rd_en = rd; s_w_data = 8'($urandom_range(255, 0));
      if (rd_ok) exp_data = q.pop_front();
      if (wr_ok) q.push_back(s_w_data);
      tick();
      checks++;
      if (s_r_data !== exp_data || s_count !== 5'(q.size()) || s_count > 5'd8) begin
        errors++;
        $display("[TB] FAIL wrap_%0d: got data=%h count=%0d expected %h/%0d",
                 c, s_r_data, s_count, exp_data, q.size());
      end
    end
    s_wr_en = 0; s_rd_en = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      s_wr_en = 1; s_w_data = 8'(8'hC0 + i);
      tick();
    end
    s_wr_en = 0; s_rd_en = 1;
    tick();
    s_rd_en = 0;
    checks++;
    if (s_count !== 5'd5 || s_r_data !== 8'hC0) begin
      errors++;
      $display("[TB] FAIL mid_setup: got count=%0d data=%h expected 5/c0", s_count, s_r_data);
    end
    s_wr_en = 1; s_w_data = 8'h77; reset = 1;
    tick();
    reset = 0; s_wr_en = 0;
    checks++;
    if (s_count !== 5'd0 || s_empty !== 1'b1 || s_ae !== 1'b1 || s_r_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL mid_reset: got count=%0d empty=%b ae=%b data=%h expected 0/1/1/00",
               s_count, s_empty, s_ae, s_r_data);
    end
    s_rd_en = 1;
    tick();
    s_rd_en = 0;
    checks++;
    if (s_un !== 1'b1 || s_count !== 5'd0 || s_r_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL mid_discard: got un=%b count=%0d data=%h expected 1/0/00", s_un, s_count, s_r_data);
    end
  endtask

  initial begin
    $display("[TB] starting sync_fifo_bram bench");
    test_reset();
    test_std_fill_drain();
    test_fwft_fall_through();
    test_back_to_back();
    test_underflow();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
